// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit and the data memory it drives.
package load_store_unit_pkg;

  // Access size encodings, shared with the data memory's data_size port.
  // 2'b11 is also treated as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b00;

  // Response error codes.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  // Request FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_addr_check.sv
// Combinational alignment and range check for one load/store request.
module lsu_addr_check
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        err,
  output logic [1:0]  err_code
);

  logic [2:0]  nbytes;
  logic [32:0] last_byte;
  logic        misaligned;
  logic        out_of_range;

  assign nbytes = size_bytes(size);

  // Last byte touched, kept at 33 bits so an access near 2^32 cannot wrap
  // back into the valid window.
  assign last_byte = {1'b0, addr} + {30'd0, nbytes} - 33'd1;

  assign misaligned   = ((nbytes == 3'd2) && addr[0]) ||
                        ((nbytes == 3'd4) && (addr[1:0] != 2'b00));
  assign out_of_range = (last_byte >= 33'(DEPTH));

  // Misalignment is reported in preference to a range violation.
  always_comb begin
    err_code = ERR_NONE;
    if (misaligned) begin
      err_code = ERR_MISALIGN;
    end else if (out_of_range) begin
      err_code = ERR_RANGE;
    end
    err = (err_code != ERR_NONE);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one core request at a time, checks it, drives the
// big-endian data memory port and returns a load result or error code.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_code,
  output logic [31:0] Address,
  output logic [31:0] wr_data,
  output logic        Mem_Write,
  output logic        Mem_Read,
  output logic [1:0]  data_size,
  input  logic [31:0] rd_Data
);

  // Counter value on the final Mem_Read cycle of a load.
  localparam logic [3:0] LAST_BEAT = 4'(MEM_LAT - 1);

  lsu_state_t  state_reg, state_next;
  logic [3:0]  counter_reg;
  logic        write_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;
  logic [1:0]  resp_code_reg;

  logic        chk_err;
  logic [1:0]  chk_code;
  logic        last_beat;
  logic [3:0]  keep_lane;
  logic [31:0] load_data;

  // The check looks at the incoming request so its verdict is ready on the
  // accepting edge.
  lsu_addr_check #(
    .DEPTH (DEPTH)
  ) u_addr_check (
    .addr     (req_addr),
    .size     (req_size),
    .err      (chk_err),
    .err_code (chk_code)
  );

  assign last_beat = (counter_reg == LAST_BEAT);

  // Byte lanes that survive zero-extension; the memory already sign-extends.
  always_comb begin
    keep_lane = 4'b1111;
    if (unsigned_reg) begin
      if (size_reg == SZ_BYTE) begin
        keep_lane = 4'b0001;
      end else if (size_reg == SZ_HALF) begin
        keep_lane = 4'b0011;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign load_data[gi*8 +: 8] = rd_Data[gi*8 +: 8] & {8{keep_lane[gi]}};
    end
  endgenerate

  // State register; reset abandons any in-flight access without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and port outputs; memory port is quiet outside ACCESS.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    Address    = 32'd0;
    wr_data    = 32'd0;
    data_size  = 2'b00;
    Mem_Write  = 1'b0;
    Mem_Read   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = chk_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        Address   = addr_reg;
        wr_data   = wdata_reg;
        data_size = size_reg;
        Mem_Write = write_reg;
        Mem_Read  = !write_reg;
        if (write_reg || last_beat) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, read-latency counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_reg    <= 4'd0;
      write_reg      <= 1'b0;
      size_reg       <= 2'b00;
      unsigned_reg   <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
      resp_code_reg  <= ERR_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            write_reg      <= req_write;
            size_reg       <= req_size;
            unsigned_reg   <= req_unsigned;
            addr_reg       <= req_addr;
            wdata_reg      <= req_wdata;
            counter_reg    <= 4'd0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= chk_err;
            resp_code_reg  <= chk_code;
          end
        end
        ST_ACCESS: begin
          if (!write_reg) begin
            if (last_beat) begin
              resp_rdata_reg <= load_data;
              counter_reg    <= 4'd0;
            end else begin
              counter_reg <= counter_reg + 4'd1;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
            resp_code_reg  <= ERR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata    = resp_rdata_reg;
  assign resp_err      = resp_err_reg;
  assign resp_err_code = resp_code_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: two units (MEM_LAT=1 and MEM_LAT=3) share one request
// stream; each drives its own big-endian memory model, and results are
// compared against a byte-array reference of the request semantics.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT0  = 1;
  localparam int LAT1  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b0;

  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_err;
  logic [1:0]  mw;
  logic [1:0]  mr;
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_code  [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [1:0]  dsize      [2];
  logic [31:0] rd_data    [2];

  logic [7:0]  mem0    [DEPTH];
  logic [7:0]  mem1    [DEPTH];
  logic [7:0]  ref_mem [DEPTH];

  int errors = 0;
  int checks = 0;

  int          rd_cnt [2] = '{0, 0};
  int          wr_cnt [2] = '{0, 0};
  int          overlap = 0;
  logic [31:0] op_addr [2];
  logic [31:0] op_wd   [2];
  logic [1:0]  op_sz   [2];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH), .MEM_LAT(LAT0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .resp_err_code(resp_code[0]),
    .Address(mem_addr[0]), .wr_data(mem_wdata[0]), .Mem_Write(mw[0]), .Mem_Read(mr[0]),
    .data_size(dsize[0]), .rd_Data(rd_data[0])
  );

  load_store_unit #(.DEPTH(DEPTH), .MEM_LAT(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .resp_err_code(resp_code[1]),
    .Address(mem_addr[1]), .wr_data(mem_wdata[1]), .Mem_Write(mw[1]), .Mem_Read(mr[1]),
    .data_size(dsize[1]), .rd_Data(rd_data[1])
  );

  // Data memory behaviour: big-endian, sign-extends bytes and halves.
  function automatic logic [31:0] fetch(input logic [1:0] sz, input logic [7:0] b0,
                                        input logic [7:0] b1, input logic [7:0] b2,
                                        input logic [7:0] b3);
    case (sz)
      SZ_BYTE: return {{24{b0[7]}}, b0};
      SZ_HALF: return {{16{b0[7]}}, b0, b1};
      default: return {b0, b1, b2, b3};
    endcase
  endfunction

  logic [9:0] a0, a1;
  assign a0 = mem_addr[0][9:0];
  assign a1 = mem_addr[1][9:0];
  assign rd_data[0] = fetch(dsize[0], mem0[a0], mem0[a0 + 10'd1], mem0[a0 + 10'd2], mem0[a0 + 10'd3]);
  assign rd_data[1] = fetch(dsize[1], mem1[a1], mem1[a1 + 10'd1], mem1[a1 + 10'd2], mem1[a1 + 10'd3]);

  always @(posedge clk) begin
    if (mw[0]) begin
      case (dsize[0])
        SZ_BYTE: mem0[a0] <= mem_wdata[0][7:0];
        SZ_HALF: begin
          mem0[a0] <= mem_wdata[0][15:8]; mem0[a0 + 10'd1] <= mem_wdata[0][7:0];
        end
        default: begin
          mem0[a0] <= mem_wdata[0][31:24]; mem0[a0 + 10'd1] <= mem_wdata[0][23:16];
          mem0[a0 + 10'd2] <= mem_wdata[0][15:8]; mem0[a0 + 10'd3] <= mem_wdata[0][7:0];
        end
      endcase
    end
    if (mw[1]) begin
      case (dsize[1])
        SZ_BYTE: mem1[a1] <= mem_wdata[1][7:0];
        SZ_HALF: begin
          mem1[a1] <= mem_wdata[1][15:8]; mem1[a1 + 10'd1] <= mem_wdata[1][7:0];
        end
        default: begin
          mem1[a1] <= mem_wdata[1][31:24]; mem1[a1 + 10'd1] <= mem_wdata[1][23:16];
          mem1[a1 + 10'd2] <= mem_wdata[1][15:8]; mem1[a1 + 10'd3] <= mem_wdata[1][7:0];
        end
      endcase
    end
  end

  // Bus monitor: cumulative strobe counts and the last access seen.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mr[k]) rd_cnt[k] = rd_cnt[k] + 1;
      if (mw[k]) wr_cnt[k] = wr_cnt[k] + 1;
      if (mr[k] || mw[k]) begin
        op_addr[k] = mem_addr[k];
        op_wd[k]   = mem_wdata[k];
        op_sz[k]   = dsize[k];
      end
      if (mr[k] && mw[k]) overlap = overlap + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics of one request; updates ref_mem for good stores.
  task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [1:0] code, output logic [31:0] rdata);
    int nb;
    longint last;
    logic [31:0] v;
    nb = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    last = longint'({32'd0, addr}) + nb - 1;
    if ((nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00)) code = 2'b01;
    else if (last >= DEPTH) code = 2'b10;
    else code = 2'b00;
    rdata = 32'd0;
    if (code == 2'b00) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*(nb-1-i) +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = (v << 8) | {24'd0, ref_mem[int'(addr) + i]};
        if (nb == 1) v = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (nb == 2) v = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        rdata = v;
      end
    end
  endtask

  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output logic [31:0] rd_obs);
    logic [1:0]  ecode;
    logic [31:0] edata;
    int lat [2];
    int rd0 [2];
    int wr0 [2];
    int exp_lat [2];
    int exp_rd [2];
    logic [31:0] snap [2];
    model(w, sz, uns, addr, wdata, ecode, edata);
    exp_lat[0] = (ecode != 2'b00) ? 1 : w ? 2 : 1 + LAT0;
    exp_lat[1] = (ecode != 2'b00) ? 1 : w ? 2 : 1 + LAT1;
    exp_rd[0]  = (ecode == 2'b00 && !w) ? LAT0 : 0;
    exp_rd[1]  = (ecode == 2'b00 && !w) ? LAT1 : 0;
    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    chk({tag, " req_ready"}, {30'd0, req_ready}, 32'd3);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    lat = '{0, 0};
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (resp_valid[k] && lat[k] == 0) lat[k] = c;
      if (lat[0] != 0 && lat[1] != 0) break;
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s lat%0d", tag, k), lat[k], exp_lat[k]);
      chk($sformatf("%s rdata%0d", tag, k), resp_rdata[k], edata);
      chk($sformatf("%s err%0d", tag, k), {31'd0, resp_err[k]}, {31'd0, ecode != 2'b00});
      chk($sformatf("%s code%0d", tag, k), {30'd0, resp_code[k]}, {30'd0, ecode});
      chk($sformatf("%s reads%0d", tag, k), rd_cnt[k] - rd0[k], exp_rd[k]);
      chk($sformatf("%s writes%0d", tag, k), wr_cnt[k] - wr0[k], (ecode == 2'b00 && w) ? 1 : 0);
      if (ecode == 2'b00) begin
        chk($sformatf("%s addr%0d", tag, k), op_addr[k], addr);
        chk($sformatf("%s size%0d", tag, k), {30'd0, op_sz[k]}, {30'd0, sz});
        if (w) chk($sformatf("%s wdata%0d", tag, k), op_wd[k], wdata);
      end
      snap[k] = resp_rdata[k];
    end
    rd_obs = resp_rdata[0];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%s hold_rdata%0d", tag, k), resp_rdata[k], snap[k]);
        chk($sformatf("%s hold_flags%0d", tag, k),
            {27'd0, resp_valid[k], req_ready[k], resp_err[k], resp_code[k]},
            {27'd0, 1'b1, 1'b0, ecode != 2'b00, ecode});
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s clr_flags%0d", tag, k),
          {27'd0, resp_valid[k], req_ready[k], resp_err[k], resp_code[k]}, {27'd0, 5'b01000});
      chk($sformatf("%s clr_rdata%0d", tag, k), resp_rdata[k], 32'd0);
    end
    $display("txn %-8s w=%0d sz=%0d u=%0d addr=%h wdata=%h -> code=%0d rdata=%h lat=%0d/%0d",
             tag, w, sz, uns, addr, wdata, ecode, rd_obs, lat[0], lat[1]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          sel;

    // Reset state.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset flags%0d", k),
          {25'd0, req_ready[k], resp_valid[k], resp_err[k], resp_code[k], mw[k], mr[k]},
          {25'd0, 7'b1000000});
      chk($sformatf("reset addr%0d", k), mem_addr[k] | mem_wdata[k] | resp_rdata[k], 32'd0);
    end
    rst_n = 1'b1;

    // Initialise the top of memory so boundary loads return known data.
    txn("sw_top0", 1'b1, SZ_WORD, 1'b0, 32'h3F8, 32'h01234567, 0, r);
    txn("sw_top1", 1'b1, SZ_WORD, 1'b0, 32'h3FC, 32'h89ABCDEF, 0, r);

    // Directed cases.
    txn("sw", 1'b1, SZ_WORD, 1'b0, 32'h010, 32'hDEADBEEF, 0, r);
    txn("lw", 1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0, 5, r);
    chk("lw literal", r, 32'hDEADBEEF);
    txn("lb", 1'b0, SZ_BYTE, 1'b0, 32'h011, 32'h0, 0, r);
    chk("lb literal", r, 32'hFFFFFFAD);
    txn("lbu", 1'b0, SZ_BYTE, 1'b1, 32'h011, 32'h0, 0, r);
    chk("lbu literal", r, 32'h000000AD);
    txn("lh", 1'b0, SZ_HALF, 1'b0, 32'h012, 32'h0, 0, r);
    chk("lh literal", r, 32'hFFFFBEEF);
    txn("lhu", 1'b0, SZ_HALF, 1'b1, 32'h012, 32'h0, 0, r);
    chk("lhu literal", r, 32'h0000BEEF);
    txn("lw_mis", 1'b0, SZ_WORD, 1'b0, 32'h013, 32'h0, 0, r);
    txn("lw_3fe", 1'b0, SZ_WORD, 1'b0, 32'h3FE, 32'h0, 0, r);
    txn("lw_3fc", 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, 0, r);
    chk("lw_3fc literal", r, 32'h89ABCDEF);
    txn("lb_400", 1'b0, SZ_BYTE, 1'b0, 32'h400, 32'h0, 0, r);
    txn("lh_3ff", 1'b0, SZ_HALF, 1'b0, 32'h3FF, 32'h0, 0, r);
    txn("lhu_3fe", 1'b0, SZ_HALF, 1'b1, 32'h3FE, 32'h0, 0, r);
    txn("lw_wrap", 1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFC, 32'h0, 0, r);
    txn("sw_400", 1'b1, SZ_WORD, 1'b0, 32'h400, 32'h55AA55AA, 0, r);
    txn("lw_sz11", 1'b0, 2'b11, 1'b1, 32'h010, 32'h0, 0, r);

    // Reset during the second Mem_Read cycle of the MEM_LAT=3 unit.
    @(negedge clk);
    req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort mr_before", {31'd0, mr[1]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort strobes", {28'd0, mr, mw}, 32'd0);
    chk("abort ready", {30'd0, req_ready}, 32'd3);
    chk("abort addr", mem_addr[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sel = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid != 2'b00 || mr != 2'b00) sel = sel + 1;
    end
    chk("abort no_resp", sel, 0);
    $display("txn abort    load at 0x010 discarded by reset");
    txn("lw_post", 1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0, 0, r);

    // Fill the low window with random words, then randomized traffic.
    for (int i = 0; i < 16; i++) begin
      txn("fill", 1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom, 0, r);
    end
    for (int i = 0; i < 40; i++) begin
      w   = 1'($urandom_range(0, 1));
      sz  = 2'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 5)      addr = 32'($urandom_range(0, 63));
      else if (sel < 8) addr = 32'($urandom_range(DEPTH - 8, DEPTH + 3));
      else              addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_HALF) addr[0] = 1'b0;
        else if (sz != SZ_BYTE) addr[1:0] = 2'b00;
      end
      txn("rand", w, sz, 1'($urandom_range(0, 1)), addr, $urandom,
          $urandom_range(0, 2), r);
    end

    chk("no read/write overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
